// File: rtl/tree_merge_arbiter.sv
// Two-input merge stage feeding one input of a routing switch in the
// binary-tree packet network. Each producer is buffered in a small circular
// FIFO; the FIFO heads compete round-robin for a single registered output.
// Packet contents, including the destination bits [26:24], are not modified.
module tree_merge_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [1:0]            in_valid;
  logic [1:0][WIDTH-1:0] in_data;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            not_empty;
  logic [1:0]            full;
  logic [1:0]            rdy;
  logic [1:0][WIDTH-1:0] head;

  logic                  load;
  logic                  grant;
  logic                  last_grant;

  logic                  vld_p0;
  logic [WIDTH-1:0]      data_p0;
  logic                  src_p0;
  logic [CNT_W-1:0]      cnt0_q;
  logic [CNT_W-1:0]      cnt1_q;

  assign in_valid = {in1_valid, in0_valid};
  assign in_data  = {in1_data, in0_data};

  // Ready reflects occupancy before the edge only: a pop in the same cycle
  // does not free a slot for a write, so a full FIFO always refuses.
  assign rdy       = {2{rst_n}} & ~full;
  assign push      = in_valid & rdy;
  assign in0_ready = rdy[0];
  assign in1_ready = rdy[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    assign not_empty[ch] = (occ != '0);
    assign full[ch]      = (occ == OCC_W'(DEPTH));
    assign head[ch]      = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH naturally.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push[ch]) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop[ch])  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push[ch], pop[ch]})
          2'b10:   occ <= occ + OCC_W'(1);
          2'b01:   occ <= occ - OCC_W'(1);
          default: occ <= occ;
        endcase
      end
    end

    // Packet storage carries no reset; validity is tracked by occupancy.
    always_ff @(posedge clk) begin
      if (push[ch]) mem[wr_ptr] <= in_data[ch];
    end
  end

  // Pick the winner among FIFOs that held data before this edge; a packet
  // written on the same edge is never a candidate.
  always_comb begin
    load  = (!vld_p0 || out_ready) && (not_empty != 2'b00);
    grant = 1'b0;
    if (not_empty == 2'b11) grant = ~last_grant;
    else                    grant = not_empty[1];
    pop = 2'b00;
    if (load) pop[grant] = 1'b1;
  end

  // ---- output register stage (p0): held until the switch accepts ----
  // Output register, round-robin history and delivered-packet counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      data_p0    <= '0;
      src_p0     <= 1'b0;
      last_grant <= 1'b1;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      if (load) begin
        vld_p0     <= 1'b1;
        data_p0    <= head[grant];
        src_p0     <= grant;
        last_grant <= grant;
      end else if (out_ready) begin
        vld_p0 <= 1'b0;
      end
      if (vld_p0 && out_ready) begin
        if (src_p0) cnt1_q <= cnt1_q + CNT_W'(1);
        else        cnt0_q <= cnt0_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_src   = src_p0;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule
